// File: rtl/print_arbiter_pkg.sv
// Shared types and width helpers for the print channel arbiter.
package print_arbiter_pkg;

    localparam int unsigned DATA_W = 32;

    // Sequencer states; encodings are fixed so other tooling can decode them.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    // PS register address width: register index plus byte offset bits.
    function automatic int unsigned addr_w(input int unsigned reg_number);
        return 32'($clog2(reg_number) + 2);
    endfunction

    // Index width that never collapses to zero bits.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? 32'($clog2(n)) : 32'd1;
    endfunction

endpackage

// File: rtl/print_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first set req bit at or after ptr.
module rr_pick
    import print_arbiter_pkg::*;
#(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [IW-1:0] idx
);

    // ptr is always < N, so one conditional subtraction wraps the sum.
    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= N) begin
            s = s - N;
        end
        return IW'(s);
    endfunction

    // Scan N positions starting at ptr and keep the first hit.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!valid && req[wrap_add(ptr, i)]) begin
                valid = 1'b1;
                idx   = wrap_add(ptr, i);
            end
        end
    end

endmodule

// File: rtl/print_arbiter.sv
// Round-robin arbiter and write sequencer for the SoC->PS print channel.
module print_arbiter
    import print_arbiter_pkg::*;
#(
    parameter  int unsigned NUM_REQ    = 4,
    parameter  int unsigned REG_NUMBER = 16,
    parameter  int unsigned TIMEOUT    = 1023,
    localparam int unsigned ADDR_W     = addr_w(REG_NUMBER),
    localparam int unsigned IDX_W      = idx_w(NUM_REQ),
    localparam int unsigned CNT_W      = idx_w(TIMEOUT)
) (
    input  logic                      clk_sys_i,
    input  logic                      rst_n_i,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] data_i,
    output logic [NUM_REQ-1:0]        ack_o,
    output logic [NUM_REQ-1:0]        err_o,
    output logic                      busy_o,
    output logic                      write_soc_en_o,
    output logic [ADDR_W-1:0]         data_addr_o,
    output logic [DATA_W-1:0]         data_o,
    input  logic                      finish_i
);

    state_e               state_q,  state_d;
    logic [IDX_W-1:0]     owner_q,  owner_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]     cnt_q,    cnt_d;
    logic                 en_d;
    logic                 busy_d;
    logic [ADDR_W-1:0]    addr_d;
    logic [DATA_W-1:0]    data_d;
    logic [NUM_REQ-1:0]   ack_d;
    logic [NUM_REQ-1:0]   err_d;
    logic                 finish_q;
    logic                 fin_edge_c;
    logic                 pick_valid;
    logic [IDX_W-1:0]     pick_idx;

    rr_pick #(
        .N (NUM_REQ)
    ) u_rr_pick (
        .req   (req_i),
        .ptr   (rr_ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Only a rising edge of finish counts; a level left high is stale.
    assign fin_edge_c = finish_i & ~finish_q;

    // Finish history for edge detection.
    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            finish_q <= 1'b0;
        end else begin
            finish_q <= finish_i;
        end
    end

    // Next-state and next-output logic; holds everything except the pulses by default.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        en_d     = write_soc_en_o;
        addr_d   = data_addr_o;
        data_d   = data_o;
        ack_d    = '0;
        err_d    = '0;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    owner_d = pick_idx;
                    addr_d  = addr_i[32'(pick_idx) * ADDR_W +: ADDR_W];
                    data_d  = data_i[32'(pick_idx) * DATA_W +: DATA_W];
                    cnt_d   = '0;
                    en_d    = 1'b1;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (fin_edge_c) begin
                    ack_d[owner_q] = 1'b1;
                    en_d           = 1'b0;
                    state_d        = ST_GAP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d[owner_q] = 1'b1;
                    en_d           = 1'b0;
                    state_d        = ST_GAP;
                end
            end
            ST_GAP: begin
                rr_ptr_d = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
                cnt_d    = '0;
                en_d     = 1'b0;
                state_d  = ST_IDLE;
            end
            default: begin
                en_d    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs; reset drops the bridge enable immediately.
    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q        <= ST_IDLE;
            owner_q        <= '0;
            rr_ptr_q       <= '0;
            cnt_q          <= '0;
            write_soc_en_o <= 1'b0;
            busy_o         <= 1'b0;
            data_addr_o    <= '0;
            data_o         <= '0;
            ack_o          <= '0;
            err_o          <= '0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            rr_ptr_q       <= rr_ptr_d;
            cnt_q          <= cnt_d;
            write_soc_en_o <= en_d;
            busy_o         <= busy_d;
            data_addr_o    <= addr_d;
            data_o         <= data_d;
            ack_o          <= ack_d;
            err_o          <= err_d;
        end
    end

endmodule
